// File: rtl/alu_op_decoder.sv
// RV32IM_Zbb decode stage: instruction word to ALU op bundle.
// Main + skid register keep execute back-pressure lossless.
`timescale 1ns/1ps
module alu_op_decoder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  flush_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [4:0]            alu_op_o,
  output logic [1:0]            src_a_sel_o,
  output logic                  src_b_sel_o,
  output logic [DATA_WIDTH-1:0] imm_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [4:0]            rd_o,
  output logic [4:0]            rs1_o,
  output logic [4:0]            rs2_o,
  output logic                  reg_we_o,
  output logic                  illegal_o
);

  typedef struct packed {
    logic [4:0]            alu_op;
    logic [1:0]            src_a;
    logic                  src_b;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] pc;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic                  reg_we;
    logic                  illegal;
  } bundle_t;

  localparam logic [4:0] A_ADD    = 5'b00000;
  localparam logic [4:0] A_SUB    = 5'b00001;
  localparam logic [4:0] A_SLL    = 5'b00010;
  localparam logic [4:0] A_SLT    = 5'b00011;
  localparam logic [4:0] A_SLTU   = 5'b00100;
  localparam logic [4:0] A_XOR    = 5'b00101;
  localparam logic [4:0] A_SRL    = 5'b00110;
  localparam logic [4:0] A_OR     = 5'b00111;
  localparam logic [4:0] A_AND    = 5'b01000;
  localparam logic [4:0] A_SRA    = 5'b01001;
  localparam logic [4:0] A_MUL    = 5'b01010;
  localparam logic [4:0] A_MULH   = 5'b01011;
  localparam logic [4:0] A_MULHSU = 5'b01100;
  localparam logic [4:0] A_MULHU  = 5'b01101;
  localparam logic [4:0] A_DIV    = 5'b01110;
  localparam logic [4:0] A_DIVU   = 5'b01111;
  localparam logic [4:0] A_REM    = 5'b10000;
  localparam logic [4:0] A_REMU   = 5'b10001;
  localparam logic [4:0] A_ROL    = 5'b10010;
  localparam logic [4:0] A_ROR    = 5'b10011;
  localparam logic [4:0] A_MAX    = 5'b10100;
  localparam logic [4:0] A_MAXU   = 5'b10101;
  localparam logic [4:0] A_MIN    = 5'b10110;
  localparam logic [4:0] A_MINU   = 5'b10111;
  localparam logic [4:0] A_REV8   = 5'b11000;
  localparam logic [4:0] A_ORCB   = 5'b11001;
  localparam logic [4:0] A_CPOP   = 5'b11010;
  localparam logic [4:0] A_CTZ    = 5'b11011;
  localparam logic [4:0] A_CLZ    = 5'b11100;
  localparam logic [4:0] A_SEXTB  = 5'b11101;
  localparam logic [4:0] A_SEXTH  = 5'b11110;
  localparam logic [4:0] A_ZEXTH  = 5'b11111;

  localparam logic [1:0] SA_RS1  = 2'b00;
  localparam logic [1:0] SA_PC   = 2'b01;
  localparam logic [1:0] SA_ZERO = 2'b10;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rs2f;
  logic [11:0] imm12;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] shamt;

  assign f3    = instr_i[14:12];
  assign f7    = instr_i[31:25];
  assign rs2f  = instr_i[24:20];
  assign imm12 = instr_i[31:20];
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                  instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                  instr_i[20], instr_i[30:21], 1'b0};
  assign shamt = {27'b0, instr_i[24:20]};

  bundle_t dec;
  logic    ill;
  logic    we;

  // Combinational decode of the incoming instruction word.
  always_comb begin
    dec        = '0;
    dec.pc     = pc_i;
    dec.rd     = instr_i[11:7];
    dec.rs1    = instr_i[19:15];
    dec.rs2    = rs2f;
    dec.alu_op = A_ADD;
    dec.src_a  = SA_RS1;
    dec.src_b  = 1'b0;
    ill        = 1'b0;
    we         = 1'b0;
    if (instr_i[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      unique case (instr_i[6:2])
        OPC_OP: begin
          we = 1'b1;
          unique case (f7)
            7'b0000000: begin
              unique case (f3)
                3'b000:  dec.alu_op = A_ADD;
                3'b001:  dec.alu_op = A_SLL;
                3'b010:  dec.alu_op = A_SLT;
                3'b011:  dec.alu_op = A_SLTU;
                3'b100:  dec.alu_op = A_XOR;
                3'b101:  dec.alu_op = A_SRL;
                3'b110:  dec.alu_op = A_OR;
                default: dec.alu_op = A_AND;
              endcase
            end
            7'b0100000: begin
              if (f3 == 3'b000)      dec.alu_op = A_SUB;
              else if (f3 == 3'b101) dec.alu_op = A_SRA;
              else                   ill = 1'b1;
            end
            7'b0000001: begin
              unique case (f3)
                3'b000:  dec.alu_op = A_MUL;
                3'b001:  dec.alu_op = A_MULH;
                3'b010:  dec.alu_op = A_MULHSU;
                3'b011:  dec.alu_op = A_MULHU;
                3'b100:  dec.alu_op = A_DIV;
                3'b101:  dec.alu_op = A_DIVU;
                3'b110:  dec.alu_op = A_REM;
                default: dec.alu_op = A_REMU;
              endcase
            end
            7'b0000101: begin
              unique case (f3)
                3'b100:  dec.alu_op = A_MIN;
                3'b101:  dec.alu_op = A_MINU;
                3'b110:  dec.alu_op = A_MAX;
                3'b111:  dec.alu_op = A_MAXU;
                default: ill = 1'b1;
              endcase
            end
            7'b0110000: begin
              if (f3 == 3'b001)      dec.alu_op = A_ROL;
              else if (f3 == 3'b101) dec.alu_op = A_ROR;
              else                   ill = 1'b1;
            end
            7'b0000100: begin
              if (f3 == 3'b100 && rs2f == 5'd0) dec.alu_op = A_ZEXTH;
              else                              ill = 1'b1;
            end
            default: ill = 1'b1;
          endcase
        end
        OPC_OPIMM: begin
          we        = 1'b1;
          dec.src_b = 1'b1;
          dec.imm   = imm_i;
          unique case (f3)
            3'b000: dec.alu_op = A_ADD;
            3'b010: dec.alu_op = A_SLT;
            3'b011: dec.alu_op = A_SLTU;
            3'b100: dec.alu_op = A_XOR;
            3'b110: dec.alu_op = A_OR;
            3'b111: dec.alu_op = A_AND;
            3'b001: begin
              if (f7 == 7'b0000000) begin
                dec.alu_op = A_SLL;
                dec.imm    = shamt;
              end else if (f7 == 7'b0110000) begin
                unique case (rs2f)
                  5'b00000: dec.alu_op = A_CLZ;
                  5'b00001: dec.alu_op = A_CTZ;
                  5'b00010: dec.alu_op = A_CPOP;
                  5'b00100: dec.alu_op = A_SEXTB;
                  5'b00101: dec.alu_op = A_SEXTH;
                  default:  ill = 1'b1;
                endcase
              end else begin
                ill = 1'b1;
              end
            end
            default: begin
              if (imm12 == 12'h287) begin
                dec.alu_op = A_ORCB;
              end else if (imm12 == 12'h698) begin
                dec.alu_op = A_REV8;
              end else begin
                dec.imm = shamt;
                unique case (f7)
                  7'b0000000: dec.alu_op = A_SRL;
                  7'b0100000: dec.alu_op = A_SRA;
                  7'b0110000: dec.alu_op = A_ROR;
                  default:    ill = 1'b1;
                endcase
              end
            end
          endcase
        end
        OPC_LUI: begin
          we        = 1'b1;
          dec.src_a = SA_ZERO;
          dec.src_b = 1'b1;
          dec.imm   = imm_u;
        end
        OPC_AUIPC: begin
          we        = 1'b1;
          dec.src_a = SA_PC;
          dec.src_b = 1'b1;
          dec.imm   = imm_u;
        end
        OPC_LOAD: begin
          we        = 1'b1;
          dec.src_b = 1'b1;
          dec.imm   = imm_i;
          ill       = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        OPC_STORE: begin
          dec.src_b = 1'b1;
          dec.imm   = imm_s;
          ill       = (f3 > 3'b010);
        end
        OPC_BRANCH: begin
          dec.imm = imm_b;
          unique case (f3)
            3'b000, 3'b001: dec.alu_op = A_SUB;
            3'b100, 3'b101: dec.alu_op = A_SLT;
            3'b110, 3'b111: dec.alu_op = A_SLTU;
            default:        ill = 1'b1;
          endcase
        end
        OPC_JAL: begin
          we        = 1'b1;
          dec.src_a = SA_PC;
          dec.src_b = 1'b1;
          dec.imm   = imm_j;
        end
        OPC_JALR: begin
          we        = 1'b1;
          dec.src_b = 1'b1;
          dec.imm   = imm_i;
          ill       = (f3 != 3'b000);
        end
        default: ill = 1'b1;
      endcase
    end
    dec.illegal = ill;
    dec.reg_we  = we & ~ill & (dec.rd != 5'd0);
    if (ill) dec.alu_op = A_ADD;
  end

  bundle_t main_q, main_d;
  bundle_t skid_q, skid_d;
  logic    main_v_q, main_v_d;
  logic    skid_v_q, skid_v_d;
  logic    rdy_q;
  logic    accept;
  logic    drain;

  assign in_ready_o = rdy_q & ~skid_v_q;
  assign accept     = in_valid_i & in_ready_o;
  assign drain      = main_v_q & out_ready_i;

  // Skid-buffer next state; flush wins over accept and drain.
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q) begin
      if (accept) begin
        main_d   = dec;
        main_v_d = 1'b1;
      end
    end else if (drain) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else if (accept) begin
        main_d = dec;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_d   = dec;
      skid_v_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= 1'b1;
    end
  end

  assign out_valid_o = main_v_q;
  assign alu_op_o    = main_q.alu_op;
  assign src_a_sel_o = main_q.src_a;
  assign src_b_sel_o = main_q.src_b;
  assign imm_o       = main_q.imm;
  assign pc_o        = main_q.pc;
  assign rd_o        = main_q.rd;
  assign rs1_o       = main_q.rs1;
  assign rs2_o       = main_q.rs2;
  assign reg_we_o    = main_q.reg_we;
  assign illegal_o   = main_q.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed bench for alu_op_decoder: decode and handshake.
`timescale 1ns/1ps
module tb_alu_op_decoder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [4:0]  alu_op_o;
  logic [1:0]  src_a_sel_o;
  logic        src_b_sel_o;
  logic [31:0] imm_o;
  logic [31:0] pc_o;
  logic [4:0]  rd_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic        reg_we_o;
  logic        illegal_o;

  int n_cmp = 0;
  int n_err = 0;

  alu_op_decoder #(.DATA_WIDTH(32)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .instr_i     (instr_i),
    .pc_i        (pc_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .alu_op_o    (alu_op_o),
    .src_a_sel_o (src_a_sel_o),
    .src_b_sel_o (src_b_sel_o),
    .imm_o       (imm_o),
    .pc_o        (pc_o),
    .rd_o        (rd_o),
    .rs1_o       (rs1_o),
    .rs2_o       (rs2_o),
    .reg_we_o    (reg_we_o),
    .illegal_o   (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  function automatic logic [31:0] addi_enc(int k);
    return {12'(k), 5'd0, 3'd0, 5'(k), 7'h13};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    int w;
    w = 0;
    while (!in_ready_o && w < 20) begin
      step();
      w++;
    end
    n_cmp++;
    if (in_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL issue_ready: got %b want 1", in_ready_o);
    end
    instr_i    = ins;
    pc_i       = pc;
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni      = 1'b0;
    in_valid_i  = 1'b1;
    instr_i     = 32'h02B50533;
    pc_i        = 32'h0000_0040;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (out_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL rst_out_valid: got %b want 0", out_valid_o);
    end
    n_cmp++;
    if (in_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL rst_in_ready: got %b want 0", in_ready_o);
    end
    n_cmp++;
    if (alu_op_o !== 5'd0 || imm_o !== 32'd0 || pc_o !== 32'd0) begin
      n_err++;
      $display("FAIL rst_bundle: got op %h imm %h pc %h want 0",
               alu_op_o, imm_o, pc_o);
    end
    rst_ni     = 1'b1;
    in_valid_i = 1'b0;
    step();
    n_cmp++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL rst_release: got rdy %b vld %b want 1 0",
               in_ready_o, out_valid_o);
    end
  endtask

  task automatic test_decode();
    issue(32'h02B50533, 32'h100);
    n_cmp++;
    if (out_valid_o !== 1'b1 || alu_op_o !== 5'b01010 ||
        src_b_sel_o !== 1'b0 || src_a_sel_o !== 2'b00) begin
      n_err++;
      $display("FAIL mul_op: got v %b op %b a %b b %b want 1 01010 00 0",
               out_valid_o, alu_op_o, src_a_sel_o, src_b_sel_o);
    end
    n_cmp++;
    if (rd_o !== 5'd10 || rs1_o !== 5'd10 || rs2_o !== 5'd11 ||
        reg_we_o !== 1'b1 || pc_o !== 32'h100) begin
      n_err++;
      $display("FAIL mul_regs: got rd %0d rs1 %0d rs2 %0d we %b pc %h",
               rd_o, rs1_o, rs2_o, reg_we_o, pc_o);
    end
    issue(32'h60051513, 32'h104);
    n_cmp++;
    if (alu_op_o !== 5'b11100 || illegal_o !== 1'b0) begin
      n_err++;
      $display("FAIL clz_op: got %b ill %b want 11100 0",
               alu_op_o, illegal_o);
    end
    issue(32'hFFF50513, 32'h108);
    n_cmp++;
    if (imm_o !== 32'hFFFF_FFFF || src_b_sel_o !== 1'b1 ||
        alu_op_o !== 5'b00000 || reg_we_o !== 1'b1) begin
      n_err++;
      $display("FAIL addi_imm: got imm %h b %b op %b we %b",
               imm_o, src_b_sel_o, alu_op_o, reg_we_o);
    end
    issue(32'h12345537, 32'h10C);
    n_cmp++;
    if (imm_o !== 32'h1234_5000 || src_a_sel_o !== 2'b10 ||
        src_b_sel_o !== 1'b1) begin
      n_err++;
      $display("FAIL lui: got imm %h a %b b %b want 12345000 10 1",
               imm_o, src_a_sel_o, src_b_sel_o);
    end
    issue(32'h00001517, 32'h110);
    n_cmp++;
    if (imm_o !== 32'h0000_1000 || src_a_sel_o !== 2'b01 ||
        pc_o !== 32'h110) begin
      n_err++;
      $display("FAIL auipc: got imm %h a %b pc %h want 1000 01 110",
               imm_o, src_a_sel_o, pc_o);
    end
  endtask

  task automatic test_illegal();
    issue(32'h40054533, 32'h120);
    n_cmp++;
    if (illegal_o !== 1'b1 || reg_we_o !== 1'b0 ||
        alu_op_o !== 5'd0 || out_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL xnor_ill: got ill %b we %b op %b v %b",
               illegal_o, reg_we_o, alu_op_o, out_valid_o);
    end
    issue(32'h0000007F, 32'h124);
    n_cmp++;
    if (illegal_o !== 1'b1 || reg_we_o !== 1'b0 || alu_op_o !== 5'd0) begin
      n_err++;
      $display("FAIL opc_ill: got ill %b we %b op %b",
               illegal_o, reg_we_o, alu_op_o);
    end
  endtask

  task automatic test_branch_x0();
    issue(32'h00B54463, 32'h130);
    n_cmp++;
    if (alu_op_o !== 5'b00011 || reg_we_o !== 1'b0 ||
        imm_o !== 32'd8 || src_b_sel_o !== 1'b0) begin
      n_err++;
      $display("FAIL blt: got op %b we %b imm %h b %b",
               alu_op_o, reg_we_o, imm_o, src_b_sel_o);
    end
    issue(32'h00000033, 32'h134);
    n_cmp++;
    if (reg_we_o !== 1'b0 || alu_op_o !== 5'd0 || illegal_o !== 1'b0) begin
      n_err++;
      $display("FAIL add_x0: got we %b op %b ill %b want 0 0 0",
               reg_we_o, alu_op_o, illegal_o);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int          sent;
    int          recv;
    logic        held_v;
    logic        saw_block;
    logic [31:0] held_imm;
    sent      = 0;
    recv      = 0;
    held_v    = 1'b0;
    saw_block = 1'b0;
    held_imm  = '0;
    for (int c = 0; c < 14; c++) begin
      out_ready_i = !(c >= 2 && c < 5);
      in_valid_i  = (sent < 4);
      instr_i     = addi_enc(sent + 1);
      pc_i        = 32'h200 + 32'(4 * sent);
      if (sent < 4 && !in_ready_o) saw_block = 1'b1;
      if (out_valid_o && out_ready_i) begin
        n_cmp++;
        if (imm_o !== 32'(recv + 1) || pc_o !== 32'h200 + 32'(4 * recv)) begin
          n_err++;
          $display("FAIL b2b_order: got imm %h pc %h want imm %h",
                   imm_o, pc_o, recv + 1);
        end
        recv++;
      end
      held_v   = out_valid_o && !out_ready_i;
      held_imm = imm_o;
      if (in_valid_i && in_ready_o) sent++;
      step();
      if (held_v) begin
        n_cmp++;
        if (out_valid_o !== 1'b1 || imm_o !== held_imm) begin
          n_err++;
          $display("FAIL b2b_hold: got v %b imm %h want 1 %h",
                   out_valid_o, imm_o, held_imm);
        end
      end
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    n_cmp++;
    if (recv != 4 || sent != 4 || saw_block !== 1'b1 ||
        out_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_count: got recv %0d sent %0d blk %b v %b",
               recv, sent, saw_block, out_valid_o);
    end
  endtask

  task automatic test_flush();
    logic seen;
    out_ready_i = 1'b0;
    issue(addi_enc(5), 32'h300);
    issue(addi_enc(6), 32'h304);
    n_cmp++;
    if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL flush_full: got rdy %b v %b want 0 1",
               in_ready_o, out_valid_o);
    end
    flush_i    = 1'b1;
    in_valid_i = 1'b1;
    instr_i    = addi_enc(7);
    pc_i       = 32'h308;
    step();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    n_cmp++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL flush_state: got v %b rdy %b want 0 1",
               out_valid_o, in_ready_o);
    end
    out_ready_i = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      step();
      if (out_valid_o) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL flush_leak: got %b want 0", seen);
    end
    out_ready_i = 1'b0;
    issue(addi_enc(8), 32'h310);
    flush_i    = 1'b1;
    in_valid_i = 1'b1;
    instr_i    = addi_enc(9);
    pc_i       = 32'h314;
    step();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    n_cmp++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL flush_main: got v %b rdy %b want 0 1",
               out_valid_o, in_ready_o);
    end
    out_ready_i = 1'b1;
    issue(addi_enc(10), 32'h320);
    n_cmp++;
    if (out_valid_o !== 1'b1 || imm_o !== 32'd10 || pc_o !== 32'h320) begin
      n_err++;
      $display("FAIL flush_after: got v %b imm %h pc %h want 1 a 320",
               out_valid_o, imm_o, pc_o);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_illegal();
    test_branch_x0();
    test_back_to_back();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
